uart_rx: RTL and testbench

- Asynchronous serial receiver that consumes the UART line driven by the transmitter stage.
- Recovers 8-bit characters framed as: start bit (0), 8 data bits LSB first, one parity bit, one stop bit (1).
- Presents each character with a one-cycle strobe and a framing/parity error flag.
- Sits directly downstream of the TX path; replaces the behavioural RX model with synthesizable RTL for loopback on the board.

---
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rx_if : serial line in, received character and status out  |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
interface uart_rx_if;
  logic       din;
  logic       busy;
  logic [7:0] dout;
  logic       data_strobe;
  logic       rx_error;

  modport master (
    output din,
    input  busy,
    input  dout,
    input  data_strobe,
    input  rx_error
  );

  modport slave (
    input  din,
    output busy,
    output dout,
    output data_strobe,
    output rx_error
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rx : 8-bit UART receiver, start/8 data LSB first/parity/stop |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module uart_rx #(
  parameter int   CLK_FREQUENCY = 100_000_000,
  parameter int   BAUD_RATE     = 19_200,
  parameter logic PARITY        = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  uart_rx_if.slave  bus
);

  localparam int c_baud_clocks = CLK_FREQUENCY / BAUD_RATE;
  localparam int c_half_clocks = c_baud_clocks / 2;
  localparam int c_cnt_w       = (c_baud_clocks > 1) ? $clog2(c_baud_clocks) : 1;

  localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(c_baud_clocks - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half_clocks - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [c_cnt_w-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 busy_q, busy_d;
  logic [7:0]           dout_q, dout_d;
  logic                 data_strobe_q, data_strobe_d;
  logic                 rx_error_q, rx_error_d;
  logic                 din_s;

  assign din_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sync_q        <= 2'b11;
      baud_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      dout_q        <= '0;
      data_strobe_q <= 1'b0;
      rx_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      baud_cnt_q    <= baud_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_err_q     <= par_err_d;
      busy_q        <= busy_d;
      dout_q        <= dout_d;
      data_strobe_q <= data_strobe_d;
      rx_error_q    <= rx_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sync_d        = {sync_q[0], bus.din};
    baud_cnt_d    = baud_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_err_d     = par_err_q;
    busy_d        = busy_q;
    dout_d        = dout_q;
    data_strobe_d = 1'b0;
    rx_error_d    = rx_error_q;

    case (state_q)
      ST_IDLE: begin
        if (!din_s) begin
          state_d    = ST_START;
          baud_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end

      ST_START: begin
        // A low pulse that is gone by mid start bit is treated as noise.
        if (baud_cnt_q == c_half_last) begin
          baud_cnt_d = '0;
          if (din_s) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + c_cnt_one;
        end
      end

      ST_DATA: begin
        if (baud_cnt_q == c_baud_last) begin
          baud_cnt_d = '0;
          shift_d    = {din_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PAR;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + c_cnt_one;
        end
      end

      ST_PAR: begin
        if (baud_cnt_q == c_baud_last) begin
          baud_cnt_d = '0;
          par_err_d  = (din_s != ((^shift_q) ^ PARITY));
          state_d    = ST_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + c_cnt_one;
        end
      end

      ST_STOP: begin
        // Leaving at mid stop bit lets a directly following start bit be seen.
        if (baud_cnt_q == c_baud_last) begin
          baud_cnt_d    = '0;
          dout_d        = shift_q;
          rx_error_d    = par_err_q | ~din_s;
          data_strobe_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q + c_cnt_one;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.dout        = dout_q;
  assign bus.data_strobe = data_strobe_q;
  assign bus.rx_error    = rx_error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_rx : randomized frame stimulus against a parity/stop model |
// | Revision   : 1.0                                                   |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int B      = CLK_HZ / BAUD;
  localparam int H      = B / 2;
  localparam int LAT    = 2 + H + 10 * B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if bus_o ();
  uart_rx_if bus_e ();

  uart_rx #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(1'b1)) dut_odd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_o.slave)
  );

  uart_rx #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(1'b0)) dut_even (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_e.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log: {rx_error, dout}, cycle of the strobe, busy during the strobe.
  logic [8:0] sq_o[$];
  logic [8:0] sq_e[$];
  int         sc_o[$];
  bit         sb_o[$];
  bit         seen_o;

  always @(negedge clk) begin
    if (bus_o.data_strobe === 1'b1) begin
      sq_o.push_back({bus_o.rx_error, bus_o.dout});
      sc_o.push_back(cyc);
      sb_o.push_back(bus_o.busy);
    end
    if (bus_e.data_strobe === 1'b1) sq_e.push_back({bus_e.rx_error, bus_e.dout});
    if (bus_o.busy === 1'b1) seen_o = 1'b1;
  end

  function automatic logic model_par(input logic [7:0] d, input logic mode);
    return logic'(($countones(d) % 2) != int'(mode));
  endfunction

  function automatic logic model_err(input logic [7:0] d, input logic p,
                                     input logic stop, input logic mode);
    int ones;
    ones = $countones(d) + int'(p);
    return ((ones % 2) != int'(mode)) || (stop == 1'b0);
  endfunction

  task automatic drive(input int sel, input logic v);
    if (sel == 0) bus_o.din = v;
    else          bus_e.din = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame; a zero stop bit is released high shortly after mid-bit.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic p,
                            input logic stop, output int start_cyc, output bit busy_ok);
    logic [10:0] bits;
    logic        b;
    bits      = {stop, p, d, 1'b0};
    busy_ok   = 1'b1;
    start_cyc = cyc;
    for (int k = 0; k < 11; k++) begin
      drive(sel, bits[k]);
      if (k == 0) start_cyc = cyc;
      b = (sel == 0) ? bus_o.busy : bus_e.busy;
      if (k >= 1 && k <= 9 && b !== 1'b1) busy_ok = 1'b0;
      if (k == 10 && !stop) begin
        idle(H + 4);
        drive(sel, 1'b1);
        idle(B - H - 4);
      end else begin
        idle(B);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus_o.din = 1'b1;
    bus_e.din = 1'b1;
    idle(5);
    n_vec++;
    if ({bus_o.busy, bus_o.data_strobe, bus_o.rx_error, bus_o.dout} !== 11'h000) begin
      n_err++;
      $display("FAIL reset_odd: busy/strobe/err/dout = %b %b %b %h, expected 0 0 0 00",
               bus_o.busy, bus_o.data_strobe, bus_o.rx_error, bus_o.dout);
    end
    n_vec++;
    if ({bus_e.busy, bus_e.data_strobe, bus_e.rx_error, bus_e.dout} !== 11'h000) begin
      n_err++;
      $display("FAIL reset_even: busy/strobe/err/dout = %b %b %b %h, expected 0 0 0 00",
               bus_e.busy, bus_e.data_strobe, bus_e.rx_error, bus_e.dout);
    end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_odd_frame;
    int st;
    bit bok;
    logic [8:0] exp;
    sq_o.delete(); sc_o.delete(); sb_o.delete();
    send_frame(0, 8'hA5, model_par(8'hA5, 1'b1), 1'b1, st, bok);
    idle(2 * B);
    exp = {model_err(8'hA5, model_par(8'hA5, 1'b1), 1'b1, 1'b1), 8'hA5};
    n_vec++;
    if (sq_o.size() != 1) begin
      n_err++;
      $display("FAIL a5_strobes: got %0d strobes, expected 1", sq_o.size());
    end else begin
      n_vec++;
      if (sq_o[0] !== exp) begin
        n_err++;
        $display("FAIL a5_data: got err/dout %h, expected %h", sq_o[0], exp);
      end
      n_vec++;
      if (sc_o[0] - (st + 1) < LAT - 1 || sc_o[0] - (st + 1) > LAT + 1) begin
        n_err++;
        $display("FAIL a5_latency: got %0d cycles, expected %0d +-1", sc_o[0] - (st + 1), LAT);
      end
      n_vec++;
      if (sb_o[0] !== 1'b0) begin
        n_err++;
        $display("FAIL a5_busy_at_strobe: got %b, expected 0", sb_o[0]);
      end
    end
    n_vec++;
    if (!bok) begin
      n_err++;
      $display("FAIL a5_busy_in_frame: got busy low inside frame, expected high");
    end
  endtask

  task automatic test_parity_error;
    int st;
    bit bok;
    sq_o.delete();
    send_frame(0, 8'h3C, ~model_par(8'h3C, 1'b1), 1'b1, st, bok);
    idle(2 * B);
    send_frame(0, 8'h00, model_par(8'h00, 1'b1), 1'b1, st, bok);
    idle(2 * B);
    n_vec++;
    if (sq_o.size() != 2) begin
      n_err++;
      $display("FAIL parity_strobes: got %0d strobes, expected 2", sq_o.size());
    end else begin
      n_vec++;
      if (sq_o[0] !== {1'b1, 8'h3C}) begin
        n_err++;
        $display("FAIL parity_bad: got err/dout %h, expected %h", sq_o[0], {1'b1, 8'h3C});
      end
      n_vec++;
      if (sq_o[1] !== {1'b0, 8'h00}) begin
        n_err++;
        $display("FAIL parity_clear: got err/dout %h, expected %h", sq_o[1], {1'b0, 8'h00});
      end
    end
  endtask

  task automatic test_stop_error;
    int st;
    bit bok;
    sq_o.delete();
    send_frame(0, 8'h7E, model_par(8'h7E, 1'b1), 1'b0, st, bok);
    idle(3 * B);
    n_vec++;
    if (sq_o.size() != 1) begin
      n_err++;
      $display("FAIL stop_strobes: got %0d strobes, expected 1", sq_o.size());
    end else begin
      n_vec++;
      if (sq_o[0] !== {1'b1, 8'h7E}) begin
        n_err++;
        $display("FAIL stop_data: got err/dout %h, expected %h", sq_o[0], {1'b1, 8'h7E});
      end
    end
  endtask

  task automatic test_glitch;
    sq_o.delete();
    seen_o = 1'b0;
    drive(0, 1'b0);
    idle(H / 2);
    drive(0, 1'b1);
    idle(2 * B);
    n_vec++;
    if (seen_o !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_busy_pulse: got busy never high, expected a pulse");
    end
    n_vec++;
    if (sq_o.size() != 0 || bus_o.busy !== 1'b0 || bus_o.dout !== 8'h7E) begin
      n_err++;
      $display("FAIL glitch_reject: got strobes %0d busy %b dout %h, expected 0 0 7e",
               sq_o.size(), bus_o.busy, bus_o.dout);
    end
  endtask

  task automatic test_random;
    int st;
    bit bok;
    logic [7:0] d;
    logic p, s;
    logic [8:0] exp;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      p = model_par(d, 1'b1) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) != 0);
      exp = {model_err(d, p, s, 1'b1), d};
      sq_o.delete();
      send_frame(0, d, p, s, st, bok);
      idle(2 * B);
      n_vec++;
      if (sq_o.size() != 1 || sq_o[0] !== exp) begin
        n_err++;
        $display("FAIL random_%0d: got %0d strobes first %h, expected 1 strobe %h",
                 i, sq_o.size(), (sq_o.size() > 0) ? sq_o[0] : 9'h0, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    int st;
    bit bok;
    logic [7:0] bytes[5];
    logic [10:0] bits;
    sq_e.delete();
    for (int i = 0; i < 5; i++) begin
      bytes[i] = 8'($urandom);
      send_frame(1, bytes[i], model_par(bytes[i], 1'b0), 1'b1, st, bok);
    end
    idle(2 * B);
    n_vec++;
    if (sq_e.size() != 5) begin
      n_err++;
      $display("FAIL b2b_strobes: got %0d strobes, expected 5", sq_e.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_vec++;
        if (sq_e[i] !== {1'b0, bytes[i]}) begin
          n_err++;
          $display("FAIL b2b_%0d: got err/dout %h, expected %h", i, sq_e[i], {1'b0, bytes[i]});
        end
      end
    end
    // Sixth frame is cut short by reset.
    sq_e.delete();
    bits = {1'b1, 1'b0, 8'($urandom), 1'b0};
    for (int k = 0; k < 5; k++) begin
      drive(1, bits[k]);
      idle(B);
    end
    rst_n = 1'b0;
    idle(2);
    n_vec++;
    if (bus_e.busy !== 1'b0 || bus_e.data_strobe !== 1'b0) begin
      n_err++;
      $display("FAIL midframe_reset: got busy %b strobe %b, expected 0 0",
               bus_e.busy, bus_e.data_strobe);
    end
    rst_n = 1'b1;
    drive(1, 1'b1);
    idle(12 * B);
    n_vec++;
    if (sq_e.size() != 0) begin
      n_err++;
      $display("FAIL midframe_no_strobe: got %0d strobes, expected 0", sq_e.size());
    end
  endtask

  initial begin
    bus_o.din = 1'b1;
    bus_e.din = 1'b1;
    seen_o    = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_odd_frame();
    test_parity_error();
    test_stop_error();
    test_glitch();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
